// File: rtl/dac_ctrl_pkg.sv
// Shared types and constants for the DAC sample scheduler.
package dac_ctrl_pkg;

  localparam int                DATA_W    = 10;
  localparam logic [DATA_W-1:0] IDLE_CODE = 10'h200;
  localparam int                DIV_W     = 16;
  localparam int                CNT_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TICK = 3'd1,
    ST_READ      = 3'd2,
    ST_LATCH     = 3'd3,
    ST_SEND      = 3'd4,
    ST_WAIT_DONE = 3'd5
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    r = (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/dac_sample_sched_tick.sv
// Programmable rate divider: one-cycle tick every rate_div_i+1 enabled cycles.
module rate_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic [DIV_W-1:0] rate_div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic             hit;

  // rate_div_i is compared live; if it drops below the count the counter
  // simply runs on and wraps through zero before the next match.
  assign hit = (cnt_q == rate_div_i);

  // Next count: held at zero while disabled, reload on match, else advance.
  always_comb begin
    cnt_d = cnt_q;
    if (!enable_i) begin
      cnt_d = '0;
    end else if (hit) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Divider counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = enable_i && hit;

endmodule

// File: rtl/dac_sample_sched.sv
// Sample-rate scheduler between the sample FIFO and the SPI DAC transmitter.
// Each rate tick pops one FIFO word and launches one SPI frame; an empty FIFO
// re-sends the held sample and counts an underrun. One tick that lands while
// a frame is in flight is remembered; further ones are reported as misses.
module dac_sample_sched #(
  parameter int                DATA_W    = dac_ctrl_pkg::DATA_W,
  parameter logic [DATA_W-1:0] IDLE_CODE = dac_ctrl_pkg::IDLE_CODE,
  parameter int                DIV_W     = dac_ctrl_pkg::DIV_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DIV_W-1:0]  rate_div,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_read_en,
  input  logic              spi_busy,
  output logic              spi_start,
  output logic [DATA_W-1:0] spi_data,
  output logic              underrun,
  output logic              tick_miss,
  output logic [7:0]        underrun_cnt
);

  import dac_ctrl_pkg::*;

  state_e            state_q;
  state_e            state_d;
  logic              pending_q;
  logic              pending_d;
  logic              wd_first_q;
  logic              wd_first_d;
  logic [DATA_W-1:0] spi_data_q;
  logic [DATA_W-1:0] spi_data_d;
  logic              underrun_q;
  logic              underrun_d;
  logic              tick_miss_q;
  logic              tick_miss_d;
  logic [CNT_W-1:0]  ucnt_q;
  logic [CNT_W-1:0]  ucnt_d;
  logic              tick;
  logic              serve;

  rate_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk        (clk),
    .rst        (rst),
    .enable_i   (enable),
    .rate_div_i (rate_div),
    .tick_o     (tick)
  );

  // A tick or a remembered tick is only acted on from WAIT_TICK while enabled.
  assign serve = (state_q == ST_WAIT_TICK) && enable && (tick || pending_q);

  // Next-state, strobes and bookkeeping for the scheduler FSM.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    wd_first_d   = 1'b0;
    spi_data_d   = spi_data_q;
    underrun_d   = 1'b0;
    tick_miss_d  = 1'b0;
    ucnt_d       = ucnt_q;
    fifo_read_en = 1'b0;
    spi_start    = 1'b0;

    // Ticks outside WAIT_TICK: the first is remembered, later ones dropped.
    if (tick && (state_q != ST_WAIT_TICK)) begin
      if (pending_q) begin
        tick_miss_d = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_WAIT_TICK;
        end else begin
          pending_d = 1'b0;
        end
      end

      ST_WAIT_TICK: begin
        if (!enable) begin
          state_d   = ST_IDLE;
          pending_d = 1'b0;
        end else if (serve) begin
          // A tick coinciding with pending is the same request: serve once.
          pending_d = 1'b0;
          if (!fifo_empty) begin
            state_d = ST_READ;
          end else begin
            state_d    = ST_SEND;
            underrun_d = 1'b1;
            ucnt_d     = sat_inc(ucnt_q);
          end
        end
      end

      ST_READ: begin
        fifo_read_en = 1'b1;
        state_d      = ST_LATCH;
      end

      ST_LATCH: begin
        // FIFO output is valid the cycle after the pop strobe.
        spi_data_d = fifo_data;
        state_d    = ST_SEND;
      end

      ST_SEND: begin
        if (!spi_busy) begin
          spi_start  = 1'b1;
          wd_first_d = 1'b1;
          state_d    = ST_WAIT_DONE;
        end
      end

      ST_WAIT_DONE: begin
        // busy only rises the cycle after start, so the first cycle is blind.
        if (!wd_first_q && !spi_busy) begin
          state_d = enable ? ST_WAIT_TICK : ST_IDLE;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        pending_d = 1'b0;
      end
    endcase
  end

  // FSM state and control flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pending_q  <= 1'b0;
      wd_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      wd_first_q <= wd_first_d;
    end
  end

  // Held sample, status pulses and saturating underrun counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_data_q  <= IDLE_CODE;
      underrun_q  <= 1'b0;
      tick_miss_q <= 1'b0;
      ucnt_q      <= '0;
    end else begin
      spi_data_q  <= spi_data_d;
      underrun_q  <= underrun_d;
      tick_miss_q <= tick_miss_d;
      ucnt_q      <= ucnt_d;
    end
  end

  assign spi_data     = spi_data_q;
  assign underrun     = underrun_q;
  assign tick_miss    = tick_miss_q;
  assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_dac_sample_sched.sv
// Scoreboard bench for dac_sample_sched: a transaction-level reference model
// predicts frames, pops, underruns and missed ticks; a negedge monitor checks.
module tb_dac_sample_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] rate_div;
  logic        fifo_empty;
  logic [9:0]  fifo_data;
  logic        fifo_read_en;
  logic        spi_busy;
  logic        spi_start;
  logic [9:0]  spi_data;
  logic        underrun;
  logic        tick_miss;
  logic [7:0]  underrun_cnt;

  always #5 clk = ~clk;

  dac_sample_sched dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .rate_div     (rate_div),
    .fifo_empty   (fifo_empty),
    .fifo_data    (fifo_data),
    .fifo_read_en (fifo_read_en),
    .spi_busy     (spi_busy),
    .spi_start    (spi_start),
    .spi_data     (spi_data),
    .underrun     (underrun),
    .tick_miss    (tick_miss),
    .underrun_cnt (underrun_cnt)
  );

  localparam int NLEN = 8192;

  typedef struct {
    int         c;
    logic [9:0] d;
  } frame_t;

  int     checks   = 0;
  int     failures = 0;
  int     cyc      = 0;
  logic   mon_en   = 1'b0;
  logic   seen_rd  = 1'b0;
  logic   seen_st  = 1'b0;

  // expected events (cycle numbers)
  frame_t frq[$];
  int     rdq[$];
  int     urq[$];
  int     tmq[$];

  // environment: FIFO contents and SPI frame lengths
  logic [9:0] fq[$];
  int         lens[NLEN];
  int         sk;
  int         busy_left;
  logic       busy_force;
  logic       en_nx;
  logic [15:0] rd_nx;

  // reference model state
  logic [9:0] mq[$];
  int         mk;
  logic       m_idle;
  logic       m_pending;
  int         m_free;
  int         m_E;
  logic       m_prev_en;
  logic [9:0] m_last;
  int         m_utot;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference: one served request becomes a frame with fixed latency.
  task automatic model_serve();
    int s;
    int l;
    frame_t fr;
    l = lens[mk % NLEN];
    mk++;
    if (mq.size() > 0) begin
      m_last = mq.pop_front();
      rdq.push_back(cyc + 1);
      s = cyc + 3;
    end else begin
      urq.push_back(cyc + 1);
      m_utot++;
      s = cyc + 1;
    end
    fr.c = s;
    fr.d = m_last;
    frq.push_back(fr);
    m_free = s + l + 2;
  endtask

  task automatic model_cycle();
    logic tk;
    tk = 1'b0;
    if (enable) begin
      if (!m_prev_en) begin
        m_E = cyc;
        if (m_idle) m_free = cyc + 1;
        m_idle = 1'b0;
      end
      tk = ((cyc - m_E) % (int'(rate_div) + 1)) == int'(rate_div);
    end
    m_prev_en = enable;
    if (!m_idle && cyc >= m_free) begin
      if (!enable) begin
        m_idle    = 1'b1;
        m_pending = 1'b0;
      end else if (tk || m_pending) begin
        m_pending = 1'b0;
        model_serve();
      end
    end else if (tk) begin
      if (m_pending) tmq.push_back(cyc + 1);
      else m_pending = 1'b1;
    end
  endtask

  task automatic model_reset();
    frq.delete(); rdq.delete(); urq.delete(); tmq.delete();
    fq.delete(); mq.delete();
    mk = 0; sk = 0; busy_left = 0;
    m_idle = 1'b1; m_pending = 1'b0; m_free = 0; m_E = 0;
    m_prev_en = 1'b0; m_last = 10'h200; m_utot = 0;
  endtask

  // One clock: drive inputs just after the edge, then advance the model.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    enable   = en_nx;
    rate_div = rd_nx;
    if (seen_rd && fq.size() > 0) fifo_data = fq.pop_front();
    fifo_empty = (fq.size() == 0);
    if (seen_st) begin
      busy_left = lens[sk % NLEN];
      sk++;
    end
    spi_busy = busy_force || (busy_left > 0);
    if (busy_left > 0) busy_left--;
    model_cycle();
  endtask

  // Monitor: compare DUT strobes against the expected-event queues.
  always @(negedge clk) begin
    logic ex;
    seen_rd <= fifo_read_en;
    seen_st <= spi_start;
    if (mon_en) begin
      ex = (frq.size() > 0) && (frq[0].c == cyc);
      if (spi_start || ex) begin
        chk("spi_start", spi_start, ex);
        if (spi_start && ex) chk("spi_data", spi_data, frq[0].d);
        if (ex) void'(frq.pop_front());
      end
      ex = (rdq.size() > 0) && (rdq[0] == cyc);
      if (fifo_read_en || ex) begin
        chk("fifo_read_en", fifo_read_en, ex);
        if (ex) void'(rdq.pop_front());
      end
      ex = (urq.size() > 0) && (urq[0] == cyc);
      if (underrun || ex) begin
        chk("underrun", underrun, ex);
        if (ex) void'(urq.pop_front());
      end
      ex = (tmq.size() > 0) && (tmq[0] == cyc);
      if (tick_miss || ex) begin
        chk("tick_miss", tick_miss, ex);
        if (ex) void'(tmq.pop_front());
      end
    end
  end

  task automatic run_phase(input string nm, input int rd, input int nfill, input logic seqd,
                           input int lmin, input int lmax, input int ncyc);
    logic [9:0] v;
    int exp_cnt;
    rd_nx = 16'(rd);
    for (int i = 0; i < ncyc + 8; i++) lens[(mk + i) % NLEN] = $urandom_range(lmax, lmin);
    for (int i = 0; i < nfill; i++) begin
      v = seqd ? 10'(i + 1) : 10'($urandom);
      fq.push_back(v);
      mq.push_back(v);
    end
    en_nx = 1'b1;
    repeat (ncyc) step();
    en_nx = 1'b0;
    repeat (60) step();
    exp_cnt = (m_utot > 255) ? 255 : m_utot;
    chk({nm, "_leftover_events"}, frq.size() + rdq.size() + urq.size() + tmq.size(), 0);
    chk({nm, "_underrun_cnt"}, underrun_cnt, exp_cnt);
    chk({nm, "_fifo_level"}, fq.size(), mq.size());
    chk({nm, "_tick_cnt_held"}, dut.u_tick.cnt_q, 0);
    chk({nm, "_idle_no_start"}, spi_start, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; rate_div = 16'd3; fifo_empty = 1'b1;
    fifo_data = 10'h0; spi_busy = 1'b0; busy_force = 1'b0;
    en_nx = 1'b0; rd_nx = 16'd3;
    for (int i = 0; i < NLEN; i++) lens[i] = 1;
    model_reset();

    repeat (3) step();
    chk("rst_spi_start", spi_start, 0);
    chk("rst_read_en", fifo_read_en, 0);
    chk("rst_spi_data", spi_data, 10'h200);
    chk("rst_underrun", underrun, 0);
    chk("rst_tick_miss", tick_miss, 0);
    chk("rst_underrun_cnt", underrun_cnt, 0);

    // Get stuck in SEND on an underrun frame, then reset asynchronously.
    rst = 1'b0;
    busy_force = 1'b1;
    en_nx = 1'b1;
    repeat (8) step();
    chk("pre_rst_underrun_cnt", underrun_cnt, 1);
    chk("pre_rst_start_held", spi_start, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_spi_start", spi_start, 0);
    chk("arst_read_en", fifo_read_en, 0);
    chk("arst_spi_data", spi_data, 10'h200);
    chk("arst_underrun", underrun, 0);
    chk("arst_tick_miss", tick_miss, 0);
    chk("arst_underrun_cnt", underrun_cnt, 0);
    en_nx = 1'b0;
    busy_force = 1'b0;
    repeat (2) step();
    model_reset();
    rst = 1'b0;
    repeat (2) step();
    mon_en = 1'b1;

    // 100-cycle ticks, four queued samples, then three underrun ticks.
    run_phase("A", 99, 4, 1'b1, 20, 20, 700);
    chk("A_three_underruns", underrun_cnt, 3);

    // Tick every cycle against 20-cycle frames: pending plus misses.
    run_phase("B", 0, 5, 1'b0, 20, 20, 150);

    for (int p = 0; p < 6; p++) begin
      run_phase("R", $urandom_range(40, 0), $urandom_range(8, 0), 1'b0,
                1, 25, $urandom_range(500, 150));
    end

    // Long run of underruns to saturate the counter.
    run_phase("S", 3, 0, 1'b0, 1, 1, 1300);
    chk("S_saturated", underrun_cnt, 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dac_sample_sched.md
# dac_sample_sched

Sample-rate scheduler sitting between the 10-bit sample FIFO and the SPI DAC transmitter. On every programmable rate tick it pops one sample from the FIFO and launches one SPI frame with it. If the FIFO is empty at a tick, it re-sends the last sample and counts an underrun. Ticks that arrive while a frame is still in flight are buffered one deep, and further ticks are counted as misses.

## Interface
- DATA_W, 10, sample width (matches FIFO and DAC word)
- IDLE_CODE, 10'h200, value of the held sample after reset (DAC midscale)
- DIV_W, 16, width of rate divider
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  run scheduler; low = stop after the current frame
- rate_div  in  DIV_W  tick period minus 1 (0 = tick every cycle), sampled live
- fifo_empty  in  1  FIFO empty flag
- fifo_data  in  DATA_W  FIFO data_out (valid the cycle after fifo_read_en)
- fifo_read_en  out  1  one-cycle FIFO pop strobe
- spi_busy  in  1  SPI transmitter busy; rises the cycle after spi_start
- spi_start  out  1  one-cycle frame launch
- spi_data  out  DATA_W  held sample presented to SPI; stable from spi_start until the next capture
- underrun  out  1  one-cycle pulse per underrun tick
- tick_miss  out  1  one-cycle pulse when a tick is dropped
- underrun_cnt  out  8  saturating underrun count

## Operation
- Tick counter:
  - Counts 0..rate_div while enable=1. tick=1 when count==rate_div, then reloads 0.
  - Held at 0 when enable=0.
  - If rate_div drops below count, the next compare wraps naturally; no special case.
- States: IDLE, WAIT_TICK, READ, LATCH, SEND, WAIT_DONE.
- IDLE -> WAIT_TICK when enable=1.
- WAIT_TICK on tick, or with pending=1:
  - If fifo_empty=0 -> READ.
  - Else -> SEND: pulse underrun, increment underrun_cnt (saturate at 255), keep spi_data.
  - Clear pending.
- WAIT_TICK with enable=0 -> IDLE.
- READ: fifo_read_en=1 for exactly this cycle -> LATCH.
- LATCH: spi_data <= fifo_data -> SEND.
- SEND: spi_start = (state==SEND && !spi_busy); when asserted -> WAIT_DONE. Otherwise wait in SEND.
- WAIT_DONE:
  - Ignore spi_busy in the first cycle.
  - Afterwards, on spi_busy=0 -> WAIT_TICK if enable=1, else IDLE.
- Tick in any state other than WAIT_TICK:
  - If pending=0, set pending.
  - Otherwise pulse tick_miss.
- pending clears when enable=0 and the FSM reaches IDLE.
- enable deassert mid-frame: finish through WAIT_DONE. Never abort a frame; never start a new read.
- Simultaneous tick and pending in WAIT_TICK: serve once, drop the tick silently (pending already represents it).

## Timing
- Reset values: state=IDLE, fifo_read_en=0, spi_start=0, spi_data=IDLE_CODE, underrun=0, tick_miss=0, underrun_cnt=0, pending=0, tick counter=0.
- Reset mid-operation returns to these values immediately. No frame completion is required.
- Normal path, tick in cycle T:
  - fifo_read_en high in T+1.
  - spi_data updated at end of T+2.
  - spi_start high in T+3 if spi_busy=0.
- Underrun path, tick in T: underrun and spi_start both high in T+1 (busy=0).
- Minimum tick period for loss-free operation is 3 + frame length + 1 cycles.

## Structure
- Package dac_ctrl_pkg: state enum, DATA_W, IDLE_CODE.
- Sub-module rate_tick_gen (enable, rate_div -> tick) holds the divider counter.
- FSM, pending flag and counters live in dac_sample_sched.

## Test plan
- Reset: rst high mid-SEND -> all outputs at reset values, spi_data=10'h200, next frame only after a new tick.
- rate_div=99, FIFO preloaded with 0x001..0x004, spi_busy high for 20 cycles after each start:
  - Expect 4 frames exactly 100 cycles apart.
  - fifo_read_en 2 cycles before each spi_start; spi_data=0x001..0x004.
- Drain FIFO, then 3 more ticks:
  - 3 frames carrying 0x004.
  - 3 underrun pulses, underrun_cnt=3.
  - No fifo_read_en.
- rate_div=0, frame 20 cycles: pending absorbs the first extra tick, tick_miss pulses for the rest, no frame lost or duplicated beyond one per served tick.
- enable low while spi_busy high: frame completes, FSM reaches IDLE, no further read_en/start. Tick counter held at 0.
- 300 underruns: underrun_cnt stops at 255.
